// File: rtl/regfile_mp_23rv.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_23rv
// Purpose  : Multi-port integer register file with a per-register busy
//            scoreboard. NUM_READ combinational read ports, NUM_WRITE
//            synchronous write ports, optional same-cycle write-to-read
//            bypass. x0 is hardwired to zero and is never busy.
// Ports    : clk          - rising-edge clock
//            reset_n      - asynchronous active-low reset
//            rs           - packed read indices, port i at [i*AW +: AW]
//            rdata        - packed read data,    port i at [i*DW +: DW]
//            rbusy        - per read port: rs[i] has an outstanding write
//            we/rd/wd     - per write port enable / index / data
//            issue_valid  - mark issue_rd busy on this edge
//            issue_rd     - destination being issued
//            wr_conflict  - registered: >=2 enabled writes hit the same
//                           nonzero rd in the previous cycle
// Revision : 1.0 - initial multi-port release
// ============================================================================
module regfile_mp_23rv #(
  parameter int ADDRESS_BITWIDTH = 5,
  parameter int DATA_WIDTH       = 32,
  parameter int NUM_READ         = 2,
  parameter int NUM_WRITE        = 2,
  parameter int BYPASS           = 1
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [NUM_READ*ADDRESS_BITWIDTH-1:0] rs,
  output logic [NUM_READ*DATA_WIDTH-1:0]       rdata,
  output logic [NUM_READ-1:0]                  rbusy,
  input  logic [NUM_WRITE-1:0]                 we,
  input  logic [NUM_WRITE*ADDRESS_BITWIDTH-1:0] rd,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]      wd,
  input  logic                                 issue_valid,
  input  logic [ADDRESS_BITWIDTH-1:0]          issue_rd,
  output logic                                 wr_conflict
);

  localparam int c_DEPTH = 1 << ADDRESS_BITWIDTH;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]       r_regs [c_DEPTH];
  logic [c_DEPTH-1:0]          r_busy;
  logic                        r_conflict;

  // --------------------------------------------------------------------------
  // Unpacked views of the packed port vectors
  // --------------------------------------------------------------------------
  logic [ADDRESS_BITWIDTH-1:0] w_rs    [NUM_READ];
  logic [ADDRESS_BITWIDTH-1:0] w_rd    [NUM_WRITE];
  logic [DATA_WIDTH-1:0]       w_wd    [NUM_WRITE];
  logic [NUM_WRITE-1:0]        w_wr_act;
  logic [DATA_WIDTH-1:0]       w_rdata [NUM_READ];
  logic [NUM_READ-1:0]         w_rbusy;
  logic [c_DEPTH-1:0]          w_busy_nxt;
  logic                        w_conflict;

  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      w_rs[i] = rs[i*ADDRESS_BITWIDTH +: ADDRESS_BITWIDTH];
    end
    for (int j = 0; j < NUM_WRITE; j++) begin
      w_rd[j]     = rd[j*ADDRESS_BITWIDTH +: ADDRESS_BITWIDTH];
      w_wd[j]     = wd[j*DATA_WIDTH +: DATA_WIDTH];
      // A write to x0 is a no-op for storage, scoreboard and conflict.
      w_wr_act[j] = we[j] && (w_rd[j] != '0);
    end
  end

  // --------------------------------------------------------------------------
  // Register storage. Ports are applied in ascending order so the last
  // (highest-index) matching port is the one that lands on a collision.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < c_DEPTH; k++) begin
        r_regs[k] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (w_wr_act[j]) begin
          r_regs[w_rd[j]] <= w_wd[j];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Scoreboard. Clears are applied before the set so that a new producer
  // issued in the same cycle as the old producer's writeback stays busy.
  // --------------------------------------------------------------------------
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NUM_WRITE; j++) begin
      if (w_wr_act[j]) begin
        w_busy_nxt[w_rd[j]] = 1'b0;
      end
    end
    if (issue_valid && (issue_rd != '0)) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Write-collision detection: any pair of active ports on the same index.
  // --------------------------------------------------------------------------
  always_comb begin
    w_conflict = 1'b0;
    for (int a = 0; a < NUM_WRITE; a++) begin
      for (int b = a + 1; b < NUM_WRITE; b++) begin
        if (w_wr_act[a] && w_wr_act[b] && (w_rd[a] == w_rd[b])) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_conflict;
    end
  end

  assign wr_conflict = r_conflict;

  // --------------------------------------------------------------------------
  // Read ports. Bypass scans write ports in ascending order so the
  // highest-index match forwards, mirroring the storage priority. The
  // reset gate keeps a forwarded wd from leaking out while reset_n is low.
  // --------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_READ; i++) begin
      w_rdata[i] = r_regs[w_rs[i]];
      w_rbusy[i] = r_busy[w_rs[i]];
      if (BYPASS != 0) begin
        for (int j = 0; j < NUM_WRITE; j++) begin
          if (w_wr_act[j] && (w_rd[j] == w_rs[i])) begin
            w_rdata[i] = w_wd[j];
            w_rbusy[i] = 1'b0;
          end
        end
      end
      if (!reset_n || (w_rs[i] == '0)) begin
        w_rdata[i] = '0;
        w_rbusy[i] = 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rd_pack
      assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = w_rdata[gi];
      assign rbusy[gi]                          = w_rbusy[gi];
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/regfile_mp_23rv.md
# regfile_mp_23rv

Parametrised multi-port integer register file with a per-register scoreboard, the next generation of the 23RV single-write/dual-read register file. It provides NUM_READ combinational read ports, NUM_WRITE synchronous write ports, optional write-to-read bypass, and busy bits that track outstanding destination writes. It sits between decode/issue (reads, busy checks, issue marking) and the writeback stage(s) (writes, busy clear). x0 is hardwired to zero and is never busy.

## Interface
- ADDRESS_BITWIDTH, 5: register index width; depth = 2**ADDRESS_BITWIDTH.
- DATA_WIDTH, 32: register data width.
- NUM_READ, 2: number of read ports, 1 or more.
- NUM_WRITE, 2: number of write ports, 1 or more.
- BYPASS, 1: 1 forwards same-cycle write data to reads; 0 returns stored value only.

- clk  input  1  clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- rs  input  NUM_READ*ADDRESS_BITWIDTH  read indices; port i occupies bits [i*AW +: AW].
- rdata  output  NUM_READ*DATA_WIDTH  read data; port i occupies bits [i*DW +: DW].
- rbusy  output  NUM_READ  port i: the register at rs[i] has an outstanding write.
- we  input  NUM_WRITE  write enables.
- rd  input  NUM_WRITE*ADDRESS_BITWIDTH  write indices.
- wd  input  NUM_WRITE*DATA_WIDTH  write data.
- issue_valid  input  1  mark issue_rd busy.
- issue_rd  input  ADDRESS_BITWIDTH  destination being issued.
- wr_conflict  output  1  registered flag: two or more enabled write ports targeted the same nonzero rd in the previous cycle.

## Operation
- Storage: 2**AW x DW flops plus 2**AW busy bits. Entry 0 is never written and never set busy.
- Write: on each rising clk, for every port j with we[j]=1 and rd[j]!=0, regfile[rd[j]] <= wd[j].
- Write collision: when ports share a nonzero rd, the highest-index port wins. wr_conflict goes to 1 on the next cycle and stays 1 for exactly that cycle.
- Busy clear: an enabled write to a nonzero rd clears busy[rd] on that edge.
- Busy set: issue_valid=1 with issue_rd!=0 sets busy[issue_rd] on that edge.
- Set and clear on the same register in the same cycle: set wins, because the new producer supersedes the old one.
- Read, combinational:
  - rs[i]==0 → rdata[i]=0 and rbusy[i]=0.
  - BYPASS=1 and some enabled write port targets rs[i] this cycle → rdata[i]=wd of the highest-index matching port, rbusy[i]=0.
  - Otherwise rdata[i]=regfile[rs[i]] and rbusy[i]=busy[rs[i]].
- BYPASS=0 → rdata and rbusy reflect state only; a same-cycle write becomes visible after the edge.
- Widths: no arithmetic is performed; indices are used as unsigned values. All 2**AW entries are reachable.

## Timing
- Reset (reset_n=0, asynchronous): all registers 0, all busy bits 0, wr_conflict=0. While in reset, rdata=0 and rbusy=0 on every port.
- Release is synchronous to the next clk edge. The first write is accepted on the first rising edge with reset_n=1.
- Reset asserted mid-operation discards any in-flight write or issue on that edge. Busy bits are lost, so the issue stage must also be flushed.
- Write latency is 1 cycle when BYPASS=0 and 0 cycles when BYPASS=1.
- Busy-set latency is 1 cycle: an issue in cycle N shows rbusy from cycle N+1.
- Read ports are purely combinational from rs, state, and (with BYPASS=1) we/rd/wd. There is no read enable.
- wr_conflict is registered and is the only registered output.

## Test plan
- Reset and x0:
  - Stimulus: pulse reset_n low mid-cycle, then read all indices; separately write rd=0, wd=32'hDEADBEEF, and issue issue_rd=0.
  - Required: rdata=0 and rbusy=0 everywhere; x0 still reads 0 and is not busy.
- Dual write:
  - Stimulus: port0 writes x5=32'h11, port1 writes x6=32'h22 in the same cycle.
  - Required: the next cycle reads x5=32'h11 and x6=32'h22, wr_conflict=0.
- Collision:
  - Stimulus: port0 and port1 both write x7, with 32'hAAAA and 32'hBBBB.
  - Required: x7=32'hBBBB and wr_conflict=1 for one cycle. With BYPASS=1, the same-cycle read of x7 returns 32'hBBBB.
- Scoreboard lifecycle:
  - Stimulus: issue x9 in cycle N, then write x9=32'h99 in cycle N+3.
  - Required: rbusy for x9 is 1 in cycles N+1..N+3 with BYPASS=0 (N+1..N+2 with BYPASS=1), then 0 with rdata=32'h99 from cycle N+4.
- Set versus clear:
  - Stimulus: in the same cycle, issue x9 and write x9=32'h5.
  - Required: the next cycle shows x9 busy with rdata=32'h5.
- Bypass off:
  - Stimulus: BYPASS=0; write x3=32'h33 while reading x3 in the same cycle, with x3 previously 32'h0.
  - Required: rdata=32'h0 that cycle and 32'h33 the next.
